// File: rtl/perm_ctrl_pkg.sv
// Shared definitions for the permutation round controller: state encoding
// and default geometry.
package perm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } perm_state_e;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_MAX_ROUNDS = 12;

endpackage

// File: rtl/perm_round_ctrl.sv
// Round sequencer for an iterated permutation: loads a start round from the
// requested count, steps UNROLL rounds per enabled cycle and pulses done.
module perm_round_ctrl
  import perm_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MAX_ROUNDS = DEF_MAX_ROUNDS,
  parameter int UNROLL     = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] num_rounds_i,
  input  logic             en_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] round_o,
  output logic             last_rnd_o,
  output logic             done_o,
  output logic             err_o
);

  if (MAX_ROUNDS >= (1 << WIDTH) || UNROLL == 0 || UNROLL > MAX_ROUNDS) begin : g_bad_params
    $error("perm_round_ctrl: MAX_ROUNDS must fit in WIDTH bits and 1 <= UNROLL <= MAX_ROUNDS");
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_ROUNDS);
  localparam logic [WIDTH-1:0] UNR_W = WIDTH'(UNROLL);

  perm_state_e      state_q, state_d;
  logic [WIDTH-1:0] round_q, round_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   round_sum;
  logic             at_last;
  logic             num_legal;

  // One extra bit keeps the end-of-run compare free of wrap-around.
  assign round_sum = {1'b0, round_q} + {1'b0, UNR_W};
  assign at_last   = (round_sum == {1'b0, MAX_W});
  assign num_legal = (num_rounds_i != '0) && (num_rounds_i <= MAX_W) &&
                     ((num_rounds_i % UNR_W) == '0);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        round_d = '0;
        if (start_i) begin
          if (num_legal) begin
            state_d = ST_RUN;
            round_d = MAX_W - num_rounds_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          round_d = '0;
        end else if (en_i) begin
          if (at_last) begin
            state_d = ST_DONE;
          end else begin
            round_d = round_sum[WIDTH-1:0];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        round_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        round_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      err_q   <= err_d;
    end
  end

  // err_q is cleared asynchronously, so it is already low while reset is held.
  assign ready_o    = (state_q == ST_IDLE);
  assign busy_o     = (state_q == ST_RUN);
  assign round_o    = (state_q == ST_IDLE) ? '0 : round_q;
  assign last_rnd_o = (state_q == ST_RUN) && at_last;
  assign done_o     = (state_q == ST_DONE);
  assign err_o      = err_q;

endmodule

// File: tb/tb_perm_round_ctrl.sv
// Scoreboard bench for perm_round_ctrl: one instance with UNROLL=1 and one
// with UNROLL=2, per-cycle expected outputs queued by the driver.
module tb_perm_round_ctrl;

  typedef struct packed {
    logic       sel;
    logic       ready;
    logic       busy;
    logic [3:0] round;
    logic       last;
    logic       done;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start_v, en_v, abort_v;
  logic [3:0] num_v [2];
  logic [1:0] ready_v, busy_v, last_v, done_v, err_v;
  logic [3:0] round_v [2];

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  perm_round_ctrl #(.WIDTH(4), .MAX_ROUNDS(12), .UNROLL(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[0]), .num_rounds_i(num_v[0]),
    .en_i(en_v[0]), .abort_i(abort_v[0]), .ready_o(ready_v[0]), .busy_o(busy_v[0]),
    .round_o(round_v[0]), .last_rnd_o(last_v[0]), .done_o(done_v[0]), .err_o(err_v[0])
  );

  perm_round_ctrl #(.WIDTH(4), .MAX_ROUNDS(12), .UNROLL(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[1]), .num_rounds_i(num_v[1]),
    .en_i(en_v[1]), .abort_i(abort_v[1]), .ready_o(ready_v[1]), .busy_o(busy_v[1]),
    .round_o(round_v[1]), .last_rnd_o(last_v[1]), .done_o(done_v[1]), .err_o(err_v[1])
  );

  function automatic exp_t mk(logic sel, logic rdy, logic bsy, logic [3:0] rnd,
                              logic lst, logic dn, logic er);
    exp_t e;
    e.sel = sel; e.ready = rdy; e.busy = bsy; e.round = rnd;
    e.last = lst; e.done = dn; e.err = er;
    return e;
  endfunction

  function automatic exp_t idle_e(logic sel, logic er);
    return mk(sel, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, er);
  endfunction

  // Apply one cycle of inputs to the selected DUT and queue the outputs
  // expected for that same cycle.
  task automatic cyc(input logic sel, input logic st, input logic [3:0] num,
                     input logic en, input logic ab, input logic r, input exp_t e);
    @(posedge clk);
    #1;
    start_v = '0; en_v = '0; abort_v = '0;
    num_v[0] = '0; num_v[1] = '0;
    start_v[sel] = st; en_v[sel] = en; abort_v[sel] = ab; num_v[sel] = num;
    rst = r;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      exp_t a;
      int   s;
      e = q.pop_front();
      s = int'(e.sel);
      a = mk(e.sel, ready_v[s], busy_v[s], round_v[s], last_v[s], done_v[s], err_v[s]);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cyc dut%0d got rdy=%b bsy=%b rnd=%0d last=%b done=%b err=%b want rdy=%b bsy=%b rnd=%0d last=%b done=%b err=%b",
                 s + 1, a.ready, a.busy, a.round, a.last, a.done, a.err,
                 e.ready, e.busy, e.round, e.last, e.done, e.err);
      end else begin
        $display("ok   dut%0d rdy=%b bsy=%b rnd=%0d last=%b done=%b err=%b",
                 s + 1, a.ready, a.busy, a.round, a.last, a.done, a.err);
      end
    end
  end

  // Run an accepted start on dut1 with en held high until completion.
  task automatic full_run(input logic [3:0] num);
    cyc(1'b0, 1'b1, num, 1'b0, 1'b0, 1'b0, idle_e(1'b0, 1'b0));
    for (int i = 12 - int'(num); i < 12; i++)
      cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0,
          mk(1'b0, 1'b0, 1'b1, 4'(i), i == 11, 1'b0, 1'b0));
  endtask

  initial begin
    start_v = '0; en_v = '0; abort_v = '0;
    num_v[0] = '0; num_v[1] = '0;

    // Reset held: idle outputs on both the checked DUT and after release.
    cyc(1'b0, 1'b1, 4'd12, 1'b1, 1'b0, 1'b1, idle_e(1'b0, 1'b0));
    cyc(1'b1, 1'b1, 4'd12, 1'b1, 1'b0, 1'b1, idle_e(1'b1, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, idle_e(1'b0, 1'b0));

    // Full 12-round run; start in the DONE cycle must be ignored.
    full_run(4'd12);
    cyc(1'b0, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, idle_e(1'b0, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, idle_e(1'b0, 1'b0));

    // num=6 covers rounds 6..11, then a 12-round start straight after.
    full_run(4'd6);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1, 1'b0));
    cyc(1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, idle_e(1'b0, 1'b0));
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 4'(i), 1'b0, 1'b0, 1'b0));
    // Stall three cycles at round 8, then resume to the end.
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0));
    for (int i = 8; i < 12; i++)
      cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 4'(i), i == 11, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, idle_e(1'b0, 1'b0));

    // Abort at round 3 with en high; a start at round 1 is ignored.
    cyc(1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, idle_e(1'b0, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, idle_e(1'b0, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, idle_e(1'b0, 1'b0));

    // Rejected counts: single err pulse the cycle after, state stays IDLE.
    cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, idle_e(1'b0, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, idle_e(1'b0, 1'b1));
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, idle_e(1'b0, 1'b0));
    cyc(1'b0, 1'b1, 4'd13, 1'b1, 1'b0, 1'b0, idle_e(1'b0, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, idle_e(1'b0, 1'b1));
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, idle_e(1'b0, 1'b0));
    cyc(1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, idle_e(1'b1, 1'b0));
    cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, idle_e(1'b1, 1'b1));
    cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, idle_e(1'b1, 1'b0));

    // UNROLL=2, num=12: rounds 0,2,..,10 then done.
    cyc(1'b1, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0, idle_e(1'b1, 1'b0));
    for (int i = 0; i < 12; i += 2)
      cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b1, 4'(i), i == 10, 1'b0, 1'b0));
    cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 4'd10, 1'b0, 1'b1, 1'b0));
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, idle_e(1'b1, 1'b0));

    // Reset asserted mid-run while round_o shows 5.
    cyc(1'b0, 1'b1, 4'd12, 1'b1, 1'b0, 1'b0, idle_e(1'b0, 1'b0));
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 4'(i), 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, idle_e(1'b0, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, idle_e(1'b0, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, idle_e(1'b0, 1'b0));
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, idle_e(1'b0, 1'b0));

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d entries left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perm_round_ctrl.md
PERM_ROUND_CTRL -- requirements
Module: perm_round_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter and round-index width in bits.
REQ-002 SHALL have parameter MAX_ROUNDS, default 12: full permutation round count, i.e. the index of the final round plus one.
REQ-003 SHALL have parameter UNROLL, default 1: rounds executed per advancing cycle.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port start_i, input, 1 bit: request a new permutation run.
REQ-007 SHALL have port num_rounds_i, input, WIDTH bits: requested round count, sampled with start_i.
REQ-008 SHALL have port en_i, input, 1 bit: advance enable; low stalls the counter.
REQ-009 SHALL have port abort_i, input, 1 bit: cancel the current run.
REQ-010 SHALL have port ready_o, output, 1 bit: high in IDLE only.
REQ-011 SHALL have port busy_o, output, 1 bit: high in RUN.
REQ-012 SHALL have port round_o, output, WIDTH bits: constant index of the first round processed this cycle.
REQ-013 SHALL have port last_rnd_o, output, 1 bit: the current cycle completes the run.
REQ-014 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port err_o, output, 1 bit: one-cycle pulse on a rejected start.

Function
REQ-016 SHALL implement the states IDLE, RUN and DONE.
REQ-017 In IDLE, start_i with a legal num_rounds_i (1..MAX_ROUNDS and divisible by UNROLL) SHALL load round = MAX_ROUNDS - num_rounds_i and enter RUN next cycle.
REQ-018 In IDLE, start_i with an illegal num_rounds_i SHALL pulse err_o for exactly one cycle and remain in IDLE with round unchanged.
REQ-019 In RUN with en_i=1 and round+UNROLL<MAX_ROUNDS, round SHALL increment by UNROLL.
REQ-020 In RUN with en_i=1 and round+UNROLL==MAX_ROUNDS, the next state SHALL be DONE, with round held.
REQ-021 In RUN with en_i=0, the state and round SHALL hold.
REQ-022 last_rnd_o SHALL be combinational: RUN and round+UNROLL==MAX_ROUNDS, independent of en_i.
REQ-023 DONE SHALL last exactly one cycle, drive done_o=1, then return to IDLE.
REQ-024 start_i SHALL be ignored outside IDLE, including in DONE.
REQ-025 abort_i in RUN or DONE SHALL force IDLE next cycle with round=0 and no done_o; abort_i SHALL take priority over en_i; abort_i in IDLE SHALL have no effect.
REQ-026 round_o SHALL read 0 in IDLE, except that it holds the loaded value in the cycle after load only when in RUN.
REQ-027 Latency SHALL be: with en_i held high, a legal start at cycle 0 gives RUN for num_rounds_i/UNROLL cycles and done_o in cycle num_rounds_i/UNROLL+1.
REQ-028 Arithmetic SHALL be unsigned, WIDTH-bit, and never wrap; elaboration SHALL fail if MAX_ROUNDS >= 2**WIDTH or UNROLL is 0 or UNROLL > MAX_ROUNDS.

Reset
REQ-029 rst_i SHALL act immediately at any time, including mid-run, forcing state=IDLE and round=0.
REQ-030 During and after reset, ready_o SHALL be 1 and busy_o, last_rnd_o, done_o and err_o SHALL be 0.

Structure
REQ-031 The state enum and the default MAX_ROUNDS/WIDTH constants SHALL live in shared package perm_ctrl_pkg.
REQ-032 The block SHALL be a single module; no sub-module is required.

Verification
REQ-033 Bench SHALL cover: defaults, start num=12, en high -> round_o 0..11 over 12 RUN cycles, last_rnd_o only at 11, done_o one cycle later, ready_o back to 1.
REQ-034 Bench SHALL cover: num=6 -> round_o 6,7,8,9,10,11, then done_o; subsequent num=12 start accepted.
REQ-035 Bench SHALL cover: en low 3 cycles at round_o=8 -> round_o stays 8, last_rnd_o 0; resume completes at 11.
REQ-036 Bench SHALL cover: abort_i at round_o=3 with en high -> IDLE next cycle, round_o=0, no done_o; start_i during RUN ignored.
REQ-037 Bench SHALL cover: num=0, num=13, and (UNROLL=2, num=7) -> err_o single pulse, stays IDLE; UNROLL=2, num=12 -> round_o 0,2,...,10, done after 6 RUN cycles.
REQ-038 Bench SHALL cover: rst_i pulsed mid-run at round_o=5 -> same-cycle IDLE outputs, ready_o=1.
